// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Arbitrates the single-port 1Kx16 block RAM (1-cycle synchronous read)
//   between the instruction-fetch and data-access requesters. Each requester
//   uses its own req/ack handshake. Every access takes four cycles:
//   IDLE -> ACCESS -> CAPTURE -> RESP.
//   Optional feature macro: MEM_ARB_RR_EN
//     defined   : round-robin arbitration when both requesters ask at once
//     undefined : fixed priority, where data beats fetch on conflict
module mem_access_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  state_t state, state_nxt;
  owner_t grant, winner;
  logic   grant_we;
  logic   any_req;

  assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;

  // On conflict, the requester that did not win the previous grant goes next.
  always_comb begin
    winner = FETCH;
    if (i_req && d_req) begin
      winner = (last_grant == FETCH) ? DATA : FETCH;
    end else if (d_req) begin
      winner = DATA;
    end
  end

  // Remember the owner of every grant so that the next conflict can alternate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= FETCH;
    end else if (state == IDLE && any_req) begin
      last_grant <= winner;
    end
  end
`else
  // Fixed priority: data wins whenever it is requesting.
  always_comb begin
    winner = FETCH;
    if (d_req) begin
      winner = DATA;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Requests are looked at only in IDLE, so a request that
  // is still high during RESP is not treated as a new request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered RAM drive, grant latch, read-data capture and ack pulses.
  // The write strobe and the acks default low each cycle, so each one is a
  // single-cycle pulse. The address and write data hold between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= FETCH;
      grant_we <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= winner;
            if (winner == DATA) begin
              grant_we <= d_we;
              mem_we   <= d_we;
              mem_addr <= d_addr;
              mem_din  <= d_wdata;
            end else begin
              grant_we <= 1'b0;
              mem_addr <= i_addr;
            end
          end
        end
        CAPTURE: begin
          if (grant == FETCH) begin
            i_rdata <= mem_dout;
            i_ack   <= 1'b1;
          end else begin
            if (!grant_we) begin
              d_rdata <= mem_dout;
            end
            d_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
//   Randomised bench for mem_access_arbiter. A behavioural RAM stands in for
//   the block RAM. A reference model predicts which requester wins, the ack
//   cycle of each requester, the returned read data and the write-strobe
//   count. The model works from a shadow memory, plain arithmetic and the
//   arbitration rule. Set MEM_ARB_RR_EN to check the round-robin build.
module tb_mem_access_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack, mem_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  logic          init_ram;
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Reference model state.
  logic [DW-1:0] mdl_i, mdl_d;
  bit            mdl_last_d;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed(input int a);
    logic [31:0] t;
    if (a == 1) return 16'hBEEF;
    t = (a * 40503) ^ 32'h5A5A;
    return t[DW-1:0];
  endfunction

  // Behavioural single-port RAM with a 1-cycle synchronous read.
  always @(posedge clk) begin
    if (init_ram) begin
      for (int k = 0; k < (1 << AW); k++) ram[k] <= seed(k);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_din;
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The arbitration rule used by the model when both requesters ask at once.
  function automatic bit conflict_data_wins();
`ifdef MEM_ARB_RR_EN
    return !mdl_last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Issues one fetch and/or one data request on the same edge. Both are held
  // until they are acked, and the results are compared with the model.
  task automatic issue(input bit wi, input bit wd, input bit we,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic [DW-1:0] wdat);
    bit first_d, pend_i, pend_d;
    int exp_i_c, exp_d_c, got_i_c, got_d_c, we_cnt;
    logic [DW-1:0] exp_i, exp_d;
    first_d = wd && (!wi || conflict_data_wins());
    exp_i_c = 0;
    exp_d_c = 0;
    if (wi && wd) begin
      exp_d_c = first_d ? 4 : 8;
      exp_i_c = first_d ? 8 : 4;
    end else begin
      if (wi) exp_i_c = 4;
      if (wd) exp_d_c = 4;
    end
    // Serve the model in grant order so that fetch-after-write sees new data.
    if (wd && first_d) begin
      if (we) ref_mem[da] = wdat; else mdl_d = ref_mem[da];
      if (wi) mdl_i = ref_mem[ia];
    end else begin
      if (wi) mdl_i = ref_mem[ia];
      if (wd) begin
        if (we) ref_mem[da] = wdat; else mdl_d = ref_mem[da];
      end
    end
    if (wi && wd) mdl_last_d = !first_d;
    else          mdl_last_d = wd;
    exp_i = mdl_i;
    exp_d = mdl_d;

    @(posedge clk);
    #1;
    i_req = wi; d_req = wd; d_we = we;
    i_addr = ia; d_addr = da; d_wdata = wdat;
    pend_i = wi; pend_d = wd;
    got_i_c = 0; got_d_c = 0; we_cnt = 0;
    for (int c = 1; c <= 12 && (pend_i || pend_d); c++) begin
      @(negedge clk);
      if (c == 1) check_eq("busy_before_edge", 32'(busy), 32'd0);
      if (c == 2) begin
        check_eq("busy_access", 32'(busy), 32'd1);
        check_eq("mem_addr", 32'(mem_addr), 32'(first_d ? da : ia));
      end
      if (mem_we) we_cnt++;
      if (i_ack || d_ack) check_eq("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
      if (i_ack) begin got_i_c = c; pend_i = 1'b0; i_req = 1'b0; end
      if (d_ack) begin got_d_c = c; pend_d = 1'b0; d_req = 1'b0; end
    end
    @(negedge clk);
    check_eq("ack_one_cycle", 32'({i_ack, d_ack}), 32'd0);
    check_eq("i_ack_cycle", got_i_c, exp_i_c);
    check_eq("d_ack_cycle", got_d_c, exp_d_c);
    check_eq("mem_we_cycles", we_cnt, 32'(wd && we));
    check_eq("i_rdata", 32'(i_rdata), 32'(exp_i));
    check_eq("d_rdata", 32'(d_rdata), 32'(exp_d));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    check_eq("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_din", 32'(mem_din), 32'd0);
    check_eq("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    reset = 1'b0;
    mdl_i = '0; mdl_d = '0; mdl_last_d = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_ram = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < (1 << AW); k++) ref_mem[k] = seed(k);
    @(posedge clk);
    #1 init_ram = 1'b0;

    do_reset();
    // Preloaded fetch, then write and read back at the top address.
    issue(1'b1, 1'b0, 1'b0, 10'd1, 10'd0, 16'h0);
    issue(1'b0, 1'b1, 1'b1, 10'd0, 10'h3FF, 16'h1234);
    issue(1'b0, 1'b1, 1'b0, 10'd0, 10'h3FF, 16'h0);
    // Simultaneous requests.
    issue(1'b1, 1'b1, 1'b0, 10'd2, 10'd3, 16'h0);

    // Both requests held across four grants straight from reset.
    do_reset();
    begin
      bit exp_d;
      int k, last_c;
      i_addr = 10'd5; d_addr = 10'd6; d_we = 1'b0;
      @(posedge clk);
      #1 i_req = 1'b1; d_req = 1'b1;
      k = 0; last_c = 0;
      for (int c = 1; c <= 24 && k < 4; c++) begin
        @(negedge clk);
        if (i_ack || d_ack) begin
          exp_d = conflict_data_wins();
          mdl_last_d = exp_d;
          k++;
          check_eq("held_owner", 32'(d_ack), 32'(exp_d));
          check_eq("held_spacing", c - last_c, 4);
          last_c = c;
          if (k == 4) begin i_req = 1'b0; d_req = 1'b0; end
        end
      end
      check_eq("held_grants", k, 4);
      @(negedge clk);
      @(negedge clk);
      mdl_i = ref_mem[5]; mdl_d = ref_mem[6];
    end

    // Reset pulsed during the ACCESS cycle of a write.
    @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 16'hA5A5;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_mem_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_acks", 32'({i_ack, d_ack}), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mdl_i = '0; mdl_d = '0; mdl_last_d = 1'b0;
    issue(1'b0, 1'b1, 1'b1, 10'd0, 10'd7, 16'h5A5A);
    issue(1'b1, 1'b0, 1'b0, 10'd7, 10'd0, 16'h0);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      bit wi, wd;
      logic [31:0] r;
      r  = $urandom;
      wi = r[0];
      wd = r[1] | ~r[0];
      issue(wi, wd, r[2], AW'($urandom), r[2] ? AW'($urandom_range(0, 15)) : AW'($urandom),
            DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
